mem_ctrl: RTL and testbench

Byte-wide multicycle memory controller that sits directly downstream of the TinyMIPS `controller`. It consumes `memread`/`memwrite` and the datapath address/write-data, then produces `memdata` for the instruction-register byte lanes and the load path. It models a fixed-latency synchronous RAM with a configurable number of wait states. A one-cycle `mem_ready` pulse tells the controller when an access has completed.

---
 rtl/mem_ctrl_pkg.sv | 13 +
 rtl/mem_ctrl_ram.sv | 26 ++
 rtl/mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide multicycle memory controller.
package mem_ctrl_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        ACCESS = 2'b10,
        DONE   = 2'b11
    } state_e;

endpackage

// File: rtl/mem_ctrl_ram.sv
// Single-port synchronous byte array: registered write and registered read, no reset.
module mem_ctrl_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    a,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[a] <= d;
        end
        if (re) begin
            q <= mem[a];
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Multicycle memory controller with configurable wait states in front of a synchronous RAM.
// Optional sticky protocol-error flag enabled by defining MEM_CTRL_ERR_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    output logic             mem_ready,
    output logic             busy
`ifdef MEM_CTRL_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_L = 32'(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]        adr_q, adr_d;
    logic [WIDTH-1:0]        wdata_q, wdata_d;
    logic                    wr_q, wr_d;
    logic                    rdValid_q, rdValid_d;

    logic                    inRange;
    logic                    ramWe;
    logic                    ramRe;
    logic [WIDTH-1:0]        ramQ;

    assign inRange = (32'(adr_q) < DEPTH_L);
    // A reset on the ACCESS edge must keep the write from committing.
    assign ramWe   = (state_q == ACCESS) && wr_q && inRange && !rst;
    assign ramRe   = (state_q == ACCESS) && !wr_q && inRange;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        rdValid_d = rdValid_q;
        unique case (state_q)
            IDLE: begin
                if (memread || memwrite) begin
                    adr_d   = adr;
                    wdata_d = writedata;
                    wr_d    = memwrite;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACCESS: begin
                // Out-of-range reads present zero through the output mux.
                if (!wr_q) begin
                    rdValid_d = inRange;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            adr_q     <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            rdValid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            rdValid_q <= rdValid_d;
        end
    end

    mem_ctrl_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk (clk),
        .we  (ramWe),
        .re  (ramRe),
        .a   (adr_q[AW-1:0]),
        .d   (wdata_q),
        .q   (ramQ)
    );

    assign memdata   = rdValid_q ? ramQ : '0;
    assign mem_ready = (state_q == DONE);
    assign busy      = (state_q != IDLE);

`ifdef MEM_CTRL_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && memread && memwrite) begin
            err_d = 1'b1;
        end
        if (state_q == IDLE && (memread || memwrite) && !(32'(adr) < DEPTH_L)) begin
            err_d = 1'b1;
        end
        if (busy && (memread || memwrite) && (adr != adr_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and randomized checks of mem_ctrl against a simple array model.
// Two instances: default wait states over the full range, and zero wait states with a short array.
module tb_mem_ctrl;

    localparam int WS_A    = 2;
    localparam int DEPTH_A = 256;
    localparam int WS_B    = 0;
    localparam int DEPTH_B = 64;

    logic       clk;
    logic       rstA, rstB;
    logic       aRead, aWrite, bRead, bWrite;
    logic [7:0] aAdr, aWdata, bAdr, bWdata;
    logic [7:0] aData, bData;
    logic       aReady, aBusy, bReady, bBusy;
`ifdef MEM_CTRL_ERR_EN
    logic       aErr, bErr;
`endif

    int testsRun  = 0;
    int failCount = 0;

    logic [7:0] refMem [256];
    bit         refKnown [256];
    logic [7:0] lastRead;

    mem_ctrl #(.WIDTH(8), .DEPTH(DEPTH_A), .WAIT_STATES(WS_A)) dutA (
        .clk       (clk),
        .rst       (rstA),
        .memread   (aRead),
        .memwrite  (aWrite),
        .adr       (aAdr),
        .writedata (aWdata),
        .memdata   (aData),
        .mem_ready (aReady),
        .busy      (aBusy)
`ifdef MEM_CTRL_ERR_EN
        ,
        .err       (aErr)
`endif
    );

    mem_ctrl #(.WIDTH(8), .DEPTH(DEPTH_B), .WAIT_STATES(WS_B)) dutB (
        .clk       (clk),
        .rst       (rstB),
        .memread   (bRead),
        .memwrite  (bWrite),
        .adr       (bAdr),
        .writedata (bWdata),
        .memdata   (bData),
        .mem_ready (bReady),
        .busy      (bBusy)
`ifdef MEM_CTRL_ERR_EN
        ,
        .err       (bErr)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic getBusy(input bit useB);
        return useB ? bBusy : aBusy;
    endfunction

    function automatic logic getReady(input bit useB);
        return useB ? bReady : aReady;
    endfunction

    function automatic logic [7:0] getData(input bit useB);
        return useB ? bData : aData;
    endfunction

    task automatic driveReq(input bit useB, input logic rd, input logic wr,
                            input logic [7:0] a, input logic [7:0] d);
        if (useB) begin
            bRead = rd; bWrite = wr; bAdr = a; bWdata = d;
        end else begin
            aRead = rd; aWrite = wr; aAdr = a; aWdata = d;
        end
    endtask

    // Starts at a negedge with the controller in IDLE; edges counts posedges up to the ready sample.
    task automatic applyStimulus(input bit useB, input logic rd, input logic wr,
                                 input logic [7:0] a, input logic [7:0] d,
                                 input bit moveAdr, input bit holdAfter,
                                 output logic [7:0] data, output int edges,
                                 output int busyCycles);
        bit ok;
        ok = 1'b0;
        edges = 0;
        busyCycles = 0;
        data = 8'h00;
        driveReq(useB, rd, wr, a, d);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (moveAdr && edges == 1) begin
                if (useB) bAdr = a + 8'd1; else aAdr = a + 8'd1;
            end
            if (getBusy(useB)) busyCycles++;
            if (getReady(useB)) begin
                ok = 1'b1;
                data = getData(useB);
            end
        end
        if (!ok) checkOutput("ready_timeout", 32'(ok), 32'd1);
        if (!holdAfter) begin
            driveReq(useB, 1'b0, 1'b0, 8'h00, 8'h00);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Model-checked access on instance A: latency, busy span and data.
    task automatic modelAccessA(input logic rd, input logic wr,
                                input logic [7:0] a, input logic [7:0] d, input string tag);
        logic [7:0] data;
        int edges, busyCycles;
        bit isWrite;
        isWrite = wr;
        applyStimulus(1'b0, rd, wr, a, d, 1'b0, 1'b0, data, edges, busyCycles);
        checkOutput({tag, "_latency"}, 32'(edges), 32'(WS_A + 2));
        checkOutput({tag, "_busy"}, 32'(busyCycles), 32'(WS_A + 2));
        if (isWrite) begin
            refMem[a] = d;
            refKnown[a] = 1'b1;
            checkOutput({tag, "_wr_holds"}, 32'(data), 32'(lastRead));
        end else if (refKnown[a]) begin
            checkOutput({tag, "_rd_data"}, 32'(data), 32'(refMem[a]));
            lastRead = refMem[a];
        end
    endtask

    initial begin
        logic [7:0] data;
        int edges, busyCycles;
        logic [7:0] preload [4];
        logic [7:0] ra, rd8;

        preload[0] = 8'h8C; preload[1] = 8'h03; preload[2] = 8'h00; preload[3] = 8'h44;
        for (int i = 0; i < 256; i++) refKnown[i] = 1'b0;
        lastRead = 8'h00;

        driveReq(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        driveReq(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        rstA = 1'b1;
        rstB = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstA_memdata", 32'(aData), 32'd0);
        checkOutput("rstA_ready", 32'(aReady), 32'd0);
        checkOutput("rstA_busy", 32'(aBusy), 32'd0);
        checkOutput("rstB_ready", 32'(bReady), 32'd0);
`ifdef MEM_CTRL_ERR_EN
        checkOutput("rstA_err", 32'(aErr), 32'd0);
`endif
        rstA = 1'b0;
        rstB = 1'b0;

        // Write 0x5A to 0x10, then read it back and confirm memdata holds.
        modelAccessA(1'b0, 1'b1, 8'h10, 8'h5A, "wr10");
        checkOutput("wr10_memdata0", 32'(aData), 32'd0);
        modelAccessA(1'b1, 1'b0, 8'h10, 8'h00, "rd10");
        @(negedge clk);
        checkOutput("rd10_hold", 32'(aData), 32'h5A);

        // Reset during the WAIT phase of a write must not commit it.
        modelAccessA(1'b0, 1'b1, 8'h20, 8'h00, "wr20");
        driveReq(1'b0, 1'b0, 1'b1, 8'h20, 8'hFF);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_in_wait", 32'(aBusy), 32'd1);
        rstA = 1'b1;
        driveReq(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_memdata", 32'(aData), 32'd0);
        checkOutput("abort_ready", 32'(aReady), 32'd0);
        checkOutput("abort_busy", 32'(aBusy), 32'd0);
        rstA = 1'b0;
        lastRead = 8'h00;
        modelAccessA(1'b1, 1'b0, 8'h20, 8'h00, "rd20");

        // Simultaneous read and write: the write wins.
        modelAccessA(1'b1, 1'b1, 8'h30, 8'h77, "both30");
        modelAccessA(1'b1, 1'b0, 8'h30, 8'h00, "rd30");
`ifdef MEM_CTRL_ERR_EN
        checkOutput("both_err", 32'(aErr), 32'd1);
        rstA = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rstA = 1'b0;
        checkOutput("err_cleared", 32'(aErr), 32'd0);
        lastRead = 8'h00;
`endif

        // Address moving during WAIT: the latched address is used.
        modelAccessA(1'b0, 1'b1, 8'h40, 8'h11, "wr40");
        modelAccessA(1'b0, 1'b1, 8'h41, 8'h22, "wr41");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, data, edges, busyCycles);
        checkOutput("adrmove_data", 32'(data), 32'h11);
        checkOutput("adrmove_latency", 32'(edges), 32'(WS_A + 2));
        lastRead = 8'h11;
`ifdef MEM_CTRL_ERR_EN
        checkOutput("adrmove_err", 32'(aErr), 32'd1);
`endif

        // Randomized traffic over a small window so reads hit written bytes.
        for (int i = 0; i < 16; i++) begin
            modelAccessA(1'b0, 1'b1, 8'h80 + 8'(i), 8'($urandom_range(0, 255)), "rnd_pre");
        end
        for (int i = 0; i < 30; i++) begin
            ra  = 8'h80 + 8'($urandom_range(0, 15));
            rd8 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) begin
                modelAccessA(1'b1, 1'b0, ra, 8'h00, "rnd_rd");
            end else begin
                modelAccessA(1'b0, 1'b1, ra, rd8, "rnd_wr");
            end
        end

        // Zero wait states: preload, then four back-to-back held reads.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 8'(i), preload[i], 1'b0, 1'b0, data, edges, busyCycles);
            checkOutput("b_pre_latency", 32'(edges), 32'(WS_B + 2));
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 8'(i), 8'h00, 1'b0, 1'b1, data, edges, busyCycles);
            checkOutput("b2b_data", 32'(data), 32'(preload[i]));
            checkOutput("b2b_spacing", 32'(edges), (i == 0) ? 32'(WS_B + 2) : 32'(WS_B + 3));
        end
        driveReq(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        @(negedge clk);

        // Addresses past the end of the short array: writes dropped, reads zero.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h05, 8'h12, 1'b0, 1'b0, data, edges, busyCycles);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h45, 8'h99, 1'b0, 1'b0, data, edges, busyCycles);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, data, edges, busyCycles);
        checkOutput("oor_no_alias", 32'(data), 32'h12);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h45, 8'h00, 1'b0, 1'b0, data, edges, busyCycles);
        checkOutput("oor_read_zero", 32'(data), 32'h00);
        checkOutput("oor_latency", 32'(edges), 32'(WS_B + 2));
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h3F, 8'hA5, 1'b0, 1'b0, data, edges, busyCycles);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h3F, 8'h00, 1'b0, 1'b0, data, edges, busyCycles);
        checkOutput("last_in_range", 32'(data), 32'hA5);
`ifdef MEM_CTRL_ERR_EN
        checkOutput("oor_err", 32'(bErr), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
